mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 204 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO result registers.
// Signed ops run on operand magnitudes and fix the sign in a final FIX cycle.
// The multiply is either iterative shift-add (one bit per clock) or a single
// full-width product. The divide is always restoring, one quotient bit per clock.
// HI/LO change only on the FIX exit edge, or directly on an MTHI/MTLO accept.
module mult_div_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2 * WIDTH)'(1);
  localparam logic [WIDTH-1:0]   ZERO_W   = '0;
  localparam logic [WIDTH-1:0]   ALL1_W   = '1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;   // product, or {remainder, quotient}
  logic [WIDTH-1:0]     a_q, a_d;       // multiplicand magnitude
  logic [WIDTH-1:0]     b_q, b_d;       // multiplier / divisor magnitude
  logic [WIDTH-1:0]     rs_q, rs_d;     // raw dividend, returned on divide by zero
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;   // product / quotient negative
  logic                 rneg_q, rneg_d; // remainder negative
  logic                 divz_q, divz_d;
  logic                 is_div_q, is_div_d;

  logic                 sgn_op;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shl;
  logic [WIDTH:0]       div_diff;

  // Two's-complement magnitude of v when it is a signed operand.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
  endfunction

  // Conditional negate of a single-width result.
  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + ONE_W) : v;
  endfunction

  // Conditional negate of a double-width product.
  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + ONE_2W) : v;
  endfunction

  // Next-state, iteration datapath and HI/LO update.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    rs_d     = rs_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    divz_d   = divz_q;
    is_div_d = is_div_q;
    sgn_op   = (op == OP_MULT) || (op == OP_DIV);
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {1'b0, ZERO_W});
    div_shl  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_shl - {1'b0, b_q};

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              a_d      = mag(rs_data, sgn_op);
              b_d      = mag(rt_data, sgn_op);
              neg_d    = sgn_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              rneg_d   = 1'b0;
              divz_d   = 1'b0;
              is_div_d = 1'b0;
              acc_d    = {ZERO_W, mag(rt_data, sgn_op)};
              cnt_d    = '0;
              state_d  = MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d      = mag(rs_data, sgn_op);
              b_d      = mag(rt_data, sgn_op);
              neg_d    = sgn_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              rneg_d   = sgn_op & rs_data[WIDTH-1];
              divz_d   = (rt_data == ZERO_W);
              is_div_d = 1'b1;
              rs_d     = rs_data;
              acc_d    = {ZERO_W, mag(rs_data, sgn_op)};
              cnt_d    = '0;
              state_d  = DIV;
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            default: ;  // reserved ops are consumed without effect
          endcase
        end
      end
      MUL: begin
        if (MUL_ITER == 0) begin
          acc_d   = {ZERO_W, a_q} * {ZERO_W, b_q};
          state_d = FIX;
        end else begin
          // Add multiplicand into the upper half when the multiplier LSB is set,
          // then shift the whole accumulator right, carry included.
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) state_d = FIX;
        end
      end
      DIV: begin
        // Restoring step: shift in the next dividend bit, keep the difference if non-negative.
        if (div_diff[WIDTH]) acc_d = {div_shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else                 acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (divz_q) begin
            lo_d = ALL1_W;
            hi_d = rs_q;
          end else begin
            lo_d = cond_neg_w(acc_q[WIDTH-1:0], neg_q);
            hi_d = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], rneg_q);
          end
        end else begin
          {hi_d, lo_d} = cond_neg_2w(acc_q, neg_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rs_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      divz_q   <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rs_q     <= rs_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      divz_q   <= divz_d;
      is_div_q <= is_div_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign op_ready = ~busy;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: iterative DUT (WIDTH=32, MUL_ITER=1)
// plus a single-cycle-multiply DUT (MUL_ITER=0) sharing clock and reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_ready, busy, done;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data, hi, lo;

  logic        op_valid_b, op_ready_b, busy_b, done_b;
  logic [2:0]  op_b;
  logic [31:0] rs_data_b, rt_data_b, hi_b, lo_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .MUL_ITER(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  mult_div_unit #(.WIDTH(32), .MUL_ITER(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid_b), .op_ready(op_ready_b), .op(op_b),
    .rs_data(rs_data_b), .rt_data(rt_data_b), .hi(hi_b), .lo(lo_b), .busy(busy_b), .done(done_b)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request, take the accept edge, then scramble the operand inputs.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op       = o;
    rs_data  = a;
    rt_data  = b;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op       = 3'(($urandom % 4) + 4);
    rs_data  = $urandom;
    rt_data  = $urandom;
  endtask

  // Issue an op and follow it until done, watching busy, op_ready and HI/LO hold.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, output int lat, output int bcnt,
                        output bit hold_ok, output bit rdy_ok);
    logic [31:0] oh, ol;
    oh = hi;
    ol = lo;
    lat = 0;
    bcnt = 0;
    hold_ok = 1'b1;
    rdy_ok = 1'b1;
    issue(o, a, b);
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      if (op_ready !== 1'b0) rdy_ok = 1'b0;
      if (hi !== oh || lo !== ol) hold_ok = 1'b0;
      if (poke && lat == 5) begin
        op       = 3'd4;
        rs_data  = 32'hDEAD_BEEF;
        op_valid = 1'b1;
      end
      if (poke && lat == 8) op_valid = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  logic [2:0]  v_op [8] = '{3'd0, 3'd1, 3'd0, 3'd3, 3'd2, 3'd2, 3'd3, 3'd2};
  logic [31:0] v_a  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd7,
                            32'hFFFF_FFF9, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFF9};
  logic [31:0] v_b  [8] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd2,
                            32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] v_hi [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd1,
                            32'hFFFF_FFFF, 32'd0, 32'h1234_5678, 32'hFFFF_FFF9};
  logic [31:0] v_lo [8] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'd6, 32'd3,
                            32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  bit          v_pk [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, bcnt;
    bit  hold_ok, rdy_ok, saw_done;
    logic [31:0] oh, ol;

    rst_n = 1'b0;
    op_valid = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    op_valid_b = 1'b0; op_b = '0; rs_data_b = '0; rt_data_b = '0;
    #12;
    check_val("rst_hi", 64'(hi), 64'h0);
    check_val("rst_lo", 64'(lo), 64'h0);
    check_val("rst_busy", 64'(busy), 64'h0);
    check_val("rst_done", 64'(done), 64'h0);
    check_val("rst_ready", 64'(op_ready), 64'h1);

    // Release reset and accept on the very next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd4, 32'hA5A5_A5A5, 32'h0);
    check_val("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
    check_val("mthi_lo", 64'(lo), 64'h0);
    check_val("mthi_done", 64'(done), 64'h0);
    check_val("mthi_ready", 64'(op_ready), 64'h1);
    issue(3'd5, 32'h5A5A_5A5A, 32'h0);
    check_val("mtlo_lo", 64'(lo), 64'h5A5A_5A5A);
    check_val("mtlo_hi", 64'(hi), 64'hA5A5_A5A5);
    check_val("mtlo_done", 64'(done), 64'h0);

    // Reserved op: no effect, no done.
    issue(3'd6, 32'hFFFF_0000, 32'h1);
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clk);
      #1;
    end
    check_val("rsv_hi", 64'(hi), 64'hA5A5_A5A5);
    check_val("rsv_lo", 64'(lo), 64'h5A5A_5A5A);
    check_val("rsv_done", 64'(saw_done), 64'h0);
    check_val("rsv_ready", 64'(op_ready), 64'h1);

    // Multiply / divide vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], v_pk[i], lat, bcnt, hold_ok, rdy_ok);
      check_val($sformatf("v%0d_hi", i), 64'(hi), 64'(v_hi[i]));
      check_val($sformatf("v%0d_lo", i), 64'(lo), 64'(v_lo[i]));
      check_val($sformatf("v%0d_latency", i), 64'(lat), 64'd33);
      check_val($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd33);
      check_val($sformatf("v%0d_hold", i), 64'(hold_ok), 64'h1);
      check_val($sformatf("v%0d_ready_low", i), 64'(rdy_ok), 64'h1);
      check_val($sformatf("v%0d_ready_at_done", i), 64'(op_ready), 64'h1);
      @(posedge clk);
      #1;
      check_val($sformatf("v%0d_done_width", i), 64'(done), 64'h0);
    end

    // Single-cycle multiply variant: result two edges after accept.
    for (int j = 0; j < 2; j++) begin
      op_b       = (j == 0) ? 3'd1 : 3'd0;
      rs_data_b  = (j == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFD;
      rt_data_b  = (j == 0) ? 32'hFFFF_FFFF : 32'd5;
      op_valid_b = 1'b1;
      @(posedge clk);
      #1;
      op_valid_b = 1'b0;
      rs_data_b  = $urandom;
      rt_data_b  = $urandom;
      lat = 0;
      while (done_b !== 1'b1 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check_val($sformatf("m0_%0d_latency", j), 64'(lat), 64'd2);
      check_val($sformatf("m0_%0d_hi", j), 64'(hi_b), (j == 0) ? 64'hFFFF_FFFE : 64'hFFFF_FFFF);
      check_val($sformatf("m0_%0d_lo", j), 64'(lo_b), (j == 0) ? 64'h0000_0001 : 64'hFFFF_FFF1);
      check_val($sformatf("m0_%0d_ready", j), 64'(op_ready_b), 64'h1);
      check_val($sformatf("m0_%0d_busy", j), 64'(busy_b), 64'h0);
    end

    // Abort a divide with reset mid-iteration.
    oh = hi;
    ol = lo;
    issue(3'd2, 32'd100, 32'd7);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
    end
    check_val("abort_hold_hi", 64'(hi), 64'(oh));
    check_val("abort_hold_lo", 64'(lo), 64'(ol));
    check_val("abort_busy_before", 64'(busy), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_hi", 64'(hi), 64'h0);
    check_val("abort_lo", 64'(lo), 64'h0);
    check_val("abort_busy", 64'(busy), 64'h0);
    check_val("abort_done", 64'(done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check_val("abort_no_done", 64'(saw_done), 64'h0);
    check_val("abort_hi_after", 64'(hi), 64'h0);
    check_val("abort_lo_after", 64'(lo), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
